mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// Multicycle datapath control unit: fetch/decode/execute/writeback sequencing with memory handshakes.
// Optional memory-wait watchdog enabled by defining MC_MEM_TIMEOUT_EN.
module mc_control_unit #(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                PCWriteCond,
    output logic                PCWrite,
    output logic                IorD,
    output logic                ALUSrcA,
    output logic                ALUOp,
    output logic                RegWrite,
    output logic                PCSrc,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                IRWrite,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ImmgenOp,
    output logic [1:0]          MemToReg,
    output logic [3:0]          current_state,
    output logic [3:0]          next_state,
    output logic                Error
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        R_E_A    = 4'd2,
        R_E_SEG  = 4'd3,
        R_W_AS   = 4'd4,
        R_W_G    = 4'd5,
        R_W_E    = 4'd6,
        J_E_JAL  = 4'd7,
        J_E_JALR = 4'd8,
        J_W      = 4'd9,
        B_E      = 4'd10,
        M_ADDR   = 4'd11,
        M_RD     = 4'd12,
        M_WB     = 4'd13,
        M_WR     = 4'd14,
        TRAP     = 4'd15
    } state_t;

    if (OPCODE_W < 4 || OPCODE_W > 8 || MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_cfg
        $error("mc_control_unit: illegal OPCODE_W or MEM_TIMEOUT");
    end

    state_t r_state;
    state_t w_next;
    logic   w_waiting;

    // Zero is qualified by PCWriteCond outside this block.
    logic w_unused_zero;
    assign w_unused_zero = Zero;

    assign w_waiting = ((r_state == FETCH) || (r_state == M_RD) || (r_state == M_WR)) && !MemReady;

`ifdef MC_MEM_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       w_timeout;

    assign w_timeout = w_waiting && (r_wait_cnt == 8'(MEM_TIMEOUT));

    // Counts consecutive stalled cycles in one memory-wait state.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_wait_cnt <= 8'd0;
        end else if (w_next != r_state) begin
            r_wait_cnt <= 8'd0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`else
    logic w_timeout;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; unexpected opcodes in dispatch states fall into TRAP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: if (MemReady) w_next = DECODE;
            DECODE: begin
                case (Opcode)
                    OPCODE_W'(0):                             w_next = R_E_A;
                    OPCODE_W'(1), OPCODE_W'(2), OPCODE_W'(3): w_next = R_E_SEG;
                    OPCODE_W'(4):                             w_next = J_E_JALR;
                    OPCODE_W'(5):                             w_next = B_E;
                    OPCODE_W'(6):                             w_next = J_E_JAL;
                    OPCODE_W'(7), OPCODE_W'(8):               w_next = M_ADDR;
                    default:                                  w_next = TRAP;
                endcase
            end
            R_E_A: w_next = R_W_AS;
            R_E_SEG: begin
                case (Opcode)
                    OPCODE_W'(1): w_next = R_W_G;
                    OPCODE_W'(2): w_next = R_W_AS;
                    OPCODE_W'(3): w_next = R_W_E;
                    default:      w_next = TRAP;
                endcase
            end
            R_W_AS, R_W_G, R_W_E: w_next = FETCH;
            J_E_JAL, J_E_JALR:    w_next = J_W;
            J_W:                  w_next = FETCH;
            B_E:                  w_next = FETCH;
            M_ADDR: begin
                case (Opcode)
                    OPCODE_W'(7): w_next = M_RD;
                    OPCODE_W'(8): w_next = M_WR;
                    default:      w_next = TRAP;
                endcase
            end
            M_RD:    if (MemReady) w_next = M_WB;
            M_WB:    w_next = FETCH;
            M_WR:    if (MemReady) w_next = FETCH;
            TRAP:    w_next = FETCH;
            default: w_next = FETCH;
        endcase
        if (w_timeout) w_next = TRAP;
    end

    // Datapath controls decoded from the current state and the memory handshake.
    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        ALUOp       = 1'b0;
        RegWrite    = 1'b0;
        PCSrc       = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcB     = 2'd0;
        ImmgenOp    = 2'd0;
        MemToReg    = 2'd0;
        Error       = 1'b0;
        case (r_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            R_E_A: ALUSrcA = 1'b1;
            R_E_SEG: begin
                ALUSrcA = 1'b1;
                ALUOp   = 1'b1;
            end
            R_W_AS: RegWrite = 1'b1;
            R_W_G: begin
                RegWrite = 1'b1;
                MemToReg = 2'd3;
            end
            R_W_E: begin
                RegWrite = 1'b1;
                MemToReg = 2'd2;
            end
            J_E_JAL: begin
                ALUSrcB  = 2'd2;
                ImmgenOp = 2'd0;
                RegWrite = 1'b1;
            end
            J_E_JALR: begin
                ALUSrcA  = 1'b1;
                RegWrite = 1'b1;
            end
            J_W: begin
                PCWrite = 1'b1;
                PCSrc   = 1'b1;
            end
            B_E: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 1'b1;
                PCWriteCond = 1'b1;
                PCSrc       = 1'b1;
                ImmgenOp    = 2'd0;
            end
            M_ADDR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'd2;
                ImmgenOp = 2'd2;
            end
            M_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            M_WB: begin
                RegWrite = 1'b1;
                MemToReg = 2'd1;
            end
            M_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            TRAP:    Error = 1'b1;
            default: ;
        endcase
    end

    assign current_state = r_state;
    assign next_state    = w_next;

endmodule
